// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined integer ALU.
package alu_pkg;
  localparam int OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ID  = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_EQ  = 4'd3,
    OP_LT  = 4'd4,
    OP_GE  = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_LTU = 4'd9,
    OP_GEU = 4'd10,
    OP_SLL = 4'd11,
    OP_SRL = 4'd12,
    OP_SRA = 4'd13
  } op_e;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath. The sum/difference arrive precomputed so the
// pipe can register the subtractor ahead of the compare/flag logic.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic [DATA_WIDTH-1:0] diff,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  oflow
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int M  = DATA_WIDTH - 1;

  logic          add_ov, sub_ov, lt, ltu;
  logic [SW-1:0] sh;

  assign add_ov = (a[M] == b[M]) && (sum[M] != a[M]);
  assign sub_ov = (a[M] != b[M]) && (diff[M] != a[M]);
  // two's-complement signed compare from the subtractor
  assign lt     = diff[M] ^ sub_ov;
  assign ltu    = a < b;
  assign sh     = b[SW-1:0];

  always_comb begin
    res   = '0;
    oflow = 1'b0;
    case (op)
      OP_ID:  res = a;
      OP_ADD: begin res = sum;  oflow = add_ov; end
      OP_SUB: begin res = diff; oflow = sub_ov; end
      OP_EQ:  res[0] = (a == b);
      OP_LT:  res[0] = lt;
      OP_GE:  res[0] = ~lt;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LTU: res[0] = ltu;
      OP_GEU: res[0] = ~ltu;
      OP_SLL: res = a << sh;
      OP_SRL: res = a >> sh;
      OP_SRA: res = $unsigned($signed(a) >>> sh);
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready on both sides, a global-stall shift pipe,
// tag pass-through and a sticky signed-overflow flag.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   ctrl,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_oflow,
  output logic                  oflow_sticky,
  input  logic                  clear_flags
);
  logic               advance;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY:0]   vld_pipe;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[LATENCY];

  always_ff @(posedge clk) begin
    if (reset)        vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[LATENCY-1:0];
  end

  // Operand stage: loads every advancing cycle; bubble contents are don't-care.
  logic [OP_WIDTH-1:0]   op1;
  logic [DATA_WIDTH-1:0] a1, b1;
  logic [TAG_WIDTH-1:0]  tag1;

  always_ff @(posedge clk) begin
    if (reset) begin
      op1 <= '0; a1 <= '0; b1 <= '0; tag1 <= '0;
    end else if (advance) begin
      op1 <= ctrl; a1 <= in0; b1 <= in1; tag1 <= in_tag;
    end
  end

  logic [OP_WIDTH-1:0]   opc;
  logic [DATA_WIDTH-1:0] ac, bc, sumc, diffc, resc;
  logic [TAG_WIDTH-1:0]  tagc;
  logic                  ovc;

  if (LATENCY == 3) begin : g_sub_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        opc <= '0; ac <= '0; bc <= '0; sumc <= '0; diffc <= '0; tagc <= '0;
      end else if (advance) begin
        opc <= op1; ac <= a1; bc <= b1; tagc <= tag1;
        sumc <= a1 + b1; diffc <= a1 - b1;
      end
    end
  end else begin : g_sub_comb
    assign opc   = op1;
    assign ac    = a1;
    assign bc    = b1;
    assign tagc  = tag1;
    assign sumc  = a1 + b1;
    assign diffc = a1 - b1;
  end

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .op   (opc),
    .a    (ac),
    .b    (bc),
    .sum  (sumc),
    .diff (diffc),
    .res  (resc),
    .oflow(ovc)
  );

  if (LATENCY == 1) begin : g_out_comb
    assign out       = resc;
    assign out_tag   = tagc;
    assign out_oflow = ovc;
  end else begin : g_out_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        out <= '0; out_tag <= '0; out_oflow <= 1'b0;
      end else if (advance) begin
        out <= resc; out_tag <= tagc; out_oflow <= ovc;
      end
    end
  end

  // An overflowing transfer beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                                oflow_sticky <= 1'b0;
    else if (out_valid & out_ready & out_oflow) oflow_sticky <= 1'b1;
    else if (clear_flags)                     oflow_sticky <= 1'b0;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: LATENCY=2 instance driven from a vector table, LATENCY=3
// instance for stall, sticky-flag and reset-in-flight sequences.
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic iv2, ir2, or2, v2, ov2, st2, clr2;
  logic [3:0] op2;
  logic [DW-1:0] a2, b2, o2;
  logic [TW-1:0] t2i, t2o;

  logic iv3, ir3, or3, v3, ov3, st3, clr3;
  logic [3:0] op3;
  logic [DW-1:0] a3, b3, o3;
  logic [TW-1:0] t3i, t3o;

  alu_pipe #(.DATA_WIDTH(DW), .LATENCY(2), .TAG_WIDTH(TW)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .ctrl(op2),
    .in0(a2), .in1(b2), .in_tag(t2i), .out_valid(v2), .out_ready(or2),
    .out(o2), .out_tag(t2o), .out_oflow(ov2), .oflow_sticky(st2), .clear_flags(clr2)
  );

  alu_pipe #(.DATA_WIDTH(DW), .LATENCY(3), .TAG_WIDTH(TW)) u3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .ctrl(op3),
    .in0(a3), .in1(b3), .in_tag(t3i), .out_valid(v3), .out_ready(or3),
    .out(o3), .out_tag(t3o), .out_oflow(ov3), .oflow_sticky(st3), .clear_flags(clr3)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          ov;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          ov;
  } vec_t;

  exp_t q2[$], q3[$];
  exp_t e2, e3;
  vec_t vt[20];
  int total = 0, bad = 0, cyc = 0;
  bit acc3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: score outputs and log accepted inputs at negedge, then edge + 1.
  task automatic step();
    exp_t g;
    @(negedge clk);
    if (!reset && v2 && or2) begin
      if (q2.size() == 0) chk("l2_extra", o2, 64'hdead);
      else begin
        g = q2.pop_front();
        chk("l2_res", o2, g.res);
        chk("l2_ov", ov2, g.ov);
        chk("l2_tag", t2o, g.tag);
        chk("l2_lat", cyc, g.cyc);
      end
    end
    if (!reset && v3 && or3) begin
      if (q3.size() == 0) chk("l3_extra", o3, 64'hdead);
      else begin
        g = q3.pop_front();
        chk("l3_res", o3, g.res);
        chk("l3_ov", ov3, g.ov);
        chk("l3_tag", t3o, g.tag);
      end
    end
    if (!reset && iv2 && ir2) begin
      e2.cyc = cyc + 2;
      q2.push_back(e2);
    end
    acc3 = !reset && iv3 && ir3;
    if (acc3) q3.push_back(e3);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [TW-1:0] held_tag;
    int n;

    vt[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1};
    vt[1]  = '{OP_ADD, 32'h5,        32'h3,        32'h8,        1'b0};
    vt[2]  = '{OP_LT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0};
    vt[3]  = '{OP_GE,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
    vt[4]  = '{OP_LTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
    vt[5]  = '{OP_GEU, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0};
    vt[6]  = '{OP_LT,  32'h80000000, 32'h7FFFFFFF, 32'h1,        1'b0};
    vt[7]  = '{OP_EQ,  32'h7,        32'h7,        32'h1,        1'b0};
    vt[8]  = '{OP_SLL, 32'h80000000, 32'h24,       32'h0,        1'b0};
    vt[9]  = '{OP_SRL, 32'h80000000, 32'h24,       32'h08000000, 1'b0};
    vt[10] = '{OP_SRA, 32'h80000000, 32'h24,       32'hF8000000, 1'b0};
    vt[11] = '{4'd15,  32'h12345678, 32'h9,        32'h0,        1'b0};
    vt[12] = '{OP_SUB, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0};
    vt[13] = '{OP_SUB, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1};
    vt[14] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vt[15] = '{OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vt[16] = '{OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vt[17] = '{OP_ID,  32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0};
    vt[18] = '{4'd14,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0};
    vt[19] = '{OP_GE,  32'h80000000, 32'h7FFFFFFF, 32'h0,        1'b0};

    iv2 = 0; or2 = 1; clr2 = 0; op2 = '0; a2 = '0; b2 = '0; t2i = '0;
    iv3 = 0; or3 = 1; clr3 = 0; op3 = '0; a3 = '0; b3 = '0; t3i = '0;
    e2 = '{default: '0}; e3 = '{default: '0};
    repeat (3) step();
    reset = 0;
    #1;
    chk("rst2_vld", v2, 0);  chk("rst2_out", o2, 0);  chk("rst2_tag", t2o, 0);
    chk("rst2_ov", ov2, 0);  chk("rst2_st", st2, 0);  chk("rst2_rdy", ir2, 1);
    chk("rst3_vld", v3, 0);  chk("rst3_out", o3, 0);  chk("rst3_tag", t3o, 0);
    chk("rst3_ov", ov3, 0);  chk("rst3_st", st3, 0);  chk("rst3_rdy", ir3, 1);

    // Table-driven opcode sweep, LATENCY=2, out_ready held high.
    foreach (vt[i]) begin
      iv2 = 1; op2 = vt[i].op; a2 = vt[i].a; b2 = vt[i].b; t2i = TW'(i);
      e2.res = vt[i].res; e2.ov = vt[i].ov; e2.tag = TW'(i);
      step();
      if (i == 1) chk("l2_st_early", st2, 0);
      if (i == 2) chk("l2_st_set", st2, 1);
      if (i == 5) begin
        iv2 = 0; op2 = OP_ADD; a2 = '1; b2 = '1;
        step();
      end
    end
    iv2 = 0;
    repeat (4) step();
    chk("l2_drain", q2.size(), 0);
    chk("l2_st_end", st2, 1);
    clr2 = 1; step(); clr2 = 0;
    chk("l2_st_clr", st2, 0);

    // LATENCY=3: six tagged ops back to back, consumer stalls in cycles 4..7.
    n = 0; held = '0; held_tag = '0;
    for (int c = 0; c < 40; c++) begin
      or3 = !(c >= 4 && c <= 7);
      if (n < 6) begin
        iv3 = 1; t3i = TW'(n);
        op3 = (n % 2 == 0) ? OP_ADD : OP_XOR;
        a3 = 32'h1000 * n + 32'h7; b3 = 32'h11 * (n + 1);
        e3.res = (n % 2 == 0) ? a3 + b3 : a3 ^ b3;
        e3.ov = 0; e3.tag = TW'(n);
      end else iv3 = 0;
      #1;
      if (c >= 4 && c <= 7) begin
        chk("l3_stall_rdy", ir3, 0);
        chk("l3_stall_vld", v3, 1);
        if (c == 4) begin held = o3; held_tag = t3o; end
        else begin chk("l3_hold_out", o3, held); chk("l3_hold_tag", t3o, held_tag); end
      end
      step();
      if (acc3) n++;
      if (n == 6 && q3.size() == 0) break;
    end
    or3 = 1; iv3 = 0;
    chk("l3_all_in", n, 6);
    chk("l3_drained", q3.size(), 0);
    chk("l3_st_none", st3, 0);

    // Overflowing SUB transfers in the same cycle as a clear: set wins.
    iv3 = 1; op3 = OP_SUB; a3 = 32'h80000000; b3 = 32'h1; t3i = 4'd9;
    e3.res = 32'h7FFFFFFF; e3.ov = 1; e3.tag = 4'd9;
    step();
    iv3 = 0;
    for (int k = 0; k < 8 && !v3; k++) step();
    chk("l3_sub_vld", v3, 1);
    chk("l3_st_pre", st3, 0);
    clr3 = 1; step(); clr3 = 0;
    chk("l3_st_setwins", st3, 1);
    step();
    chk("l3_st_hold", st3, 1);
    clr3 = 1; step(); clr3 = 0;
    chk("l3_st_clr", st3, 0);

    // Re-arm the sticky flag so reset is seen to clear it.
    iv3 = 1; op3 = OP_ADD; a3 = 32'h7FFFFFFF; b3 = 32'h1; t3i = 4'd3;
    e3.res = 32'h80000000; e3.ov = 1; e3.tag = 4'd3;
    step();
    iv3 = 0;
    repeat (5) step();
    chk("l3_st_rearm", st3, 1);
    chk("l3_q_empty", q3.size(), 0);

    // Reset with two ops in flight: nothing may emerge afterwards.
    iv3 = 1; op3 = OP_ADD; a3 = 32'h1; b3 = 32'h2; t3i = 4'd1;
    e3.res = 32'h3; e3.ov = 0; e3.tag = 4'd1;
    step();
    t3i = 4'd2; e3.tag = 4'd2;
    step();
    iv3 = 0; reset = 1;
    q3.delete();
    step();
    reset = 0;
    #1;
    chk("rip_vld", v3, 0);
    chk("rip_st", st3, 0);
    chk("rip_rdy", ir3, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rip_no_stale", v3, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
